serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
//
// PURPOSE
//   Bit-serial sequencer for the registered full_adder cell in the 8-bit sequential adder.
//   Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
//   Feeds the full_adder one bit pair per cycle, LSB first, and routes its registered cout back as cin.
//   Collects the registered sum bits and presents {out_cout, out_sum} over a valid/ready handshake.
//
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range >= 2
//
// PORTS
//   clk        in   1      single clock; all state changes on its rising edge
//   reset      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand request
//   in_ready   out  1      controller can accept operands
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      initial carry-in
//   fa_a       out  1      bit to full_adder a
//   fa_b       out  1      bit to full_adder b
//   fa_cin     out  1      carry to full_adder cin
//   fa_s       in   1      full_adder s (registered in the cell, 1-cycle latency)
//   fa_cout    in   1      full_adder cout (registered in the cell, 1-cycle latency)
//   out_valid  out  1      result available
//   out_ready  in   1      result consumer ready
//   out_sum    out  WIDTH  sum result
//   out_cout   out  1      final carry-out
//
// BEHAVIOUR
//   Reset (reset=0, asynchronous):
//     state=IDLE; all shift registers and the counter cleared.
//     out_valid=0, out_sum=0, out_cout=0, fa_a=fa_b=fa_cin=0.
//     in_ready=1 once reset deasserts.
//   FSM states: IDLE, SHIFT, DRAIN, DONE.
//   IDLE
//     in_ready=1.
//     On in_valid&&in_ready: load opa<=in_a, opb<=in_b, cin0<=in_cin, cnt<=0, then go to SHIFT.
//   SHIFT
//     Drive fa_a=opa[0] and fa_b=opb[0].
//     fa_cin = (cnt==0) ? cin0 : fa_cout. This is combinational; fa_cout is the carry from the previous bit.
//     Each edge: shift opa/opb right by 1 and increment cnt.
//     If cnt!=0, also sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}, capturing bit cnt-1.
//     Leave SHIFT for DRAIN on the edge where cnt==WIDTH-1.
//   DRAIN
//     fa_a=fa_b=fa_cin=0.
//     One edge: sum_sh <= {fa_s, sum_sh[WIDTH-1:1]} (bit WIDTH-1), out_cout<=fa_cout, then go to DONE.
//   DONE
//     out_valid=1; out_sum=sum_sh and out_cout are held stable while out_ready=0.
//     On out_valid&&out_ready: go to IDLE.
//   in_ready=0 in SHIFT, DRAIN and DONE; in_valid is ignored there, and in_a/in_b/in_cin need not stay stable.
//   fa_a, fa_b and fa_cin are 0 in every state other than SHIFT; fa_s and fa_cout are ignored outside SHIFT (cnt>0) and DRAIN.
//   Latency: out_valid rises after the (WIDTH+1)th rising edge following the accepting edge (9 edges for WIDTH=8).
//   Throughput: at most one operation per WIDTH+3 cycles (IDLE, WIDTH x SHIFT, DRAIN, DONE).
//   Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1); no overflow flag.
//   Counter: $clog2(WIDTH) bits; it never wraps within an operation.
//   Reset mid-operation: the operation in flight is discarded, with no partial result and no out_valid pulse.
//   The next accepted operation is computed correctly regardless of stale fa_s/fa_cout.
//   The result is held in DONE indefinitely under backpressure; no new operand is accepted until the result is taken.
//
// TESTING
//   1. 8'h5A + 8'h33, cin=0 -> out_sum=8'h8D, out_cout=0; out_valid exactly 9 edges after accept.
//   2. 8'hFF + 8'h01, cin=0 -> out_sum=8'h00, out_cout=1 (full carry ripple).
//   3. 8'hFF + 8'hFF, cin=1 -> out_sum=8'hFF, out_cout=1; 8'h00 + 8'h00, cin=1 -> 8'h01, cout=0.
//   4. out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, no accept; result consumed when out_ready=1.
//   5. Assert reset after 3 SHIFT edges -> out_valid=0, in_ready=1 immediately; next op 8'h12 + 8'h34 -> 8'h46, cout=0.
//   6. Back-to-back: 200 random operand/cin triples with random out_ready -> every result matches a + b + cin; in_ready high only in IDLE.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial sequencer for a registered full-adder cell. Two WIDTH-bit
// operands and a carry-in are accepted over a valid/ready handshake. They are
// fed to the cell one bit pair per cycle, LSB first. The cell's registered
// carry is looped back as the next carry-in. The registered sum bits are
// collected and {out_cout, out_sum} is presented over a valid/ready handshake.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   in_valid   : operand request          in_ready  : operands can be taken
//   in_a/in_b  : WIDTH-bit operands       in_cin    : initial carry-in
//   fa_a/fa_b  : bit pair to the cell     fa_cin    : carry to the cell
//   fa_s       : cell sum (registered)    fa_cout   : cell carry (registered)
//   out_valid  : result available         out_ready : consumer ready
//   out_sum    : WIDTH-bit sum            out_cout  : final carry-out
//
// Timing: out_valid rises WIDTH+1 edges after the accepting edge.
// Sequence: IDLE, WIDTH x SHIFT, DRAIN, DONE.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic              cin0_q, cin0_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              cout_q, cout_d;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            cin0_q   <= 1'b0;
            cnt_q    <= '0;
            sum_sh_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin0_q   <= cin0_d;
            cnt_q    <= cnt_d;
            sum_sh_q <= sum_sh_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cin0_d   = cin0_q;
        cnt_d    = cnt_q;
        sum_sh_d = sum_sh_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    cin0_d  = in_cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                opa_d = {1'b0, opa_q[WIDTH-1:1]};
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
                // The cell output lags by one cycle. At cnt==0 it holds
                // nothing from this operation, so sum capture starts at cnt==1.
                if (cnt_q != '0) begin
                    sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                end else begin
                    sum_sh_d = sum_sh_q;
                end
                if (cnt_q == CNT_LAST) begin
                    // Clear the counter instead of letting it wrap past the top.
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_DRAIN: begin
                // Collect the last sum bit and the final carry from the cell.
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                cout_d   = fa_cout;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. The cell inputs are live only in SHIFT.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                fa_a = opa_q[0];
                fa_b = opb_q[0];
                // The first bit uses the stored carry-in. Later bits use the
                // cell's registered carry, so stale cell state is never used.
                if (cnt_q == '0) begin
                    fa_cin = cin0_q;
                end else begin
                    fa_cin = fa_cout;
                end
            end
            ST_DRAIN: begin
                in_ready = 1'b0;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign out_sum  = sum_sh_q;
    assign out_cout = cout_q;

endmodule
